instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  RV32I fetch stage directly upstream of the instruction decoder. Holds the PC,
//  issues word requests to instruction memory, buffers returned words in a small
//  in-order FIFO and presents {instruction, pc} to decode over a valid/ready
//  handshake. Honours redirects (branch/jump/jalr targets) by flushing.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset.
//  FIFO_DEPTH  2              Instruction buffer entries (power of 2, >=2). Also max outstanding requests.
// PORTS
//  clk          in   1   Clock, rising edge.
//  rst_n        in   1   Asynchronous active-low reset.
//  imem_req     out  1   Request valid to instruction memory.
//  imem_addr    out  32  Request word address (= pc_q; [1:0] always 2'b00).
//  imem_gnt     in   1   Memory accepts request this cycle.
//  imem_rvalid  in   1   Response valid (in order, >=1 cycle after gnt).
//  imem_rdata   in   32  Response instruction word.
//  instr_valid  out  1   instruction/instr_pc valid to decoder.
//  instruction  out  32  Instruction word to decoder.
//  instr_pc     out  32  PC of instruction.
//  instr_ready  in   1   Decoder consumes this cycle.
//  redirect     in   1   Flush and restart fetch at redirect_pc.
//  redirect_pc  in   32  New PC; [1:0] ignored (forced to 0).
//  misalign_err out  1   Pulse: redirect_pc[1:0]!=0 on a redirect.
// BEHAVIOUR
//  Reset (async, rst_n=0): pc_q=RESET_PC, FIFO empty, outstanding=0, drop=0;
//   imem_req=0, instr_valid=0, instruction=0, instr_pc=0, misalign_err=0.
//  Credit: imem_req = (occupancy + outstanding < FIFO_DEPTH) & ~redirect.
//  On imem_req&imem_gnt: pc_q<=pc_q+4 (wraps 32'hFFFF_FFFC->0), outstanding+1,
//   pending-PC queue pushes pc_q.
//  On imem_rvalid: outstanding-1; if drop>0 then drop-1, word discarded; else push
//   {imem_rdata, pending pc} into FIFO. Simultaneous push+pop legal at full.
//  Output: instr_valid=~empty; instruction/instr_pc = FIFO head; pop on
//   instr_valid&instr_ready. Head stays stable while instr_valid&~instr_ready.
//  Latency: rvalid at cycle N -> instr_valid at N+1 (no bypass).
//  Redirect (highest priority): pc_q<=redirect_pc&~3; FIFO flushed same edge;
//   drop<=outstanding (+1 if rvalid not counted, -1 handled: drop = outstanding
//   after this cycle's gnt/rvalid updates); imem_req forced 0 that cycle; fetch
//   resumes next cycle. A pop in the redirect cycle is still a valid consume.
//  misalign_err registered: 1 for one cycle after redirect with redirect_pc[1:0]!=0.
//  imem_rvalid with outstanding==0 is a protocol error: ignored (assert in sim).
//  Reset mid-operation: all state cleared immediately; in-flight responses after
//   reset release are not expected (memory also reset).
// CONFIGURATION
//  FETCH_BYPASS_EN defined: when FIFO empty, drop==0 and imem_rvalid, response
//   drives instruction/instr_pc/instr_valid combinationally the same cycle; if
//   instr_ready it is not written to FIFO (0-cycle latency).
//  Undefined: all responses go through FIFO; instr_valid one cycle after rvalid.
// TESTING
//  1 Reset RESET_PC=0x100, gnt=1, rvalid 1 cycle later, ready=1 -> instr_pc 0x100,0x104,0x108 back-to-back, 1/cycle.
//  2 ready=0 for 5 cycles -> FIFO fills at FIFO_DEPTH, imem_req drops to 0, head word/pc stable; ready=1 -> drains in order.
//  3 Redirect to 0x2000 with 2 outstanding -> both stale responses dropped, next instr_pc=0x2000.
//  4 Redirect to 0x2002 -> misalign_err pulses 1 cycle, fetch address 0x2000.
//  5 pc_q=0xFFFF_FFFC granted -> next imem_addr=0x0000_0000.
//  6 FETCH_BYPASS_EN: empty FIFO, rvalid+ready same cycle -> instr_valid same cycle; undefined -> next cycle.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: RV32I fetch stage with PC, credit-limited imem requests, in-order instruction buffer and redirect flush.
// Optional feature macro FETCH_BYPASS_EN: a response arriving while the buffer is empty is forwarded to decode in the same cycle.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d, pwp_q, pwp_d, prp_q, prp_d;
  logic [CW-1:0] cnt_q, cnt_d, out_q, out_d, drop_q, drop_d;
  logic          misalign_q, misalign_d;
  logic [31:0]   buf_instr [FIFO_DEPTH];
  logic [31:0]   buf_pc    [FIFO_DEPTH];
  logic [31:0]   pend_pc   [FIFO_DEPTH];
  logic          empty, rv, byp, fire, push, pop;

  assign empty = (cnt_q == '0);
  assign rv    = imem_rvalid & (out_q != '0);
`ifdef FETCH_BYPASS_EN
  assign byp   = empty & (drop_q == '0) & rv;
`else
  assign byp   = 1'b0;
`endif
  assign imem_req     = rst_n & ~redirect & (({1'b0, cnt_q} + {1'b0, out_q}) < DEPTH);
  assign imem_addr    = pc_q;
  assign fire         = imem_req & imem_gnt;
  assign instr_valid  = ~empty | byp;
  assign instruction  = ~empty ? buf_instr[rp_q] : (byp ? imem_rdata : '0);
  assign instr_pc     = ~empty ? buf_pc[rp_q] : (byp ? pend_pc[prp_q] : '0);
  assign pop          = ~empty & instr_ready;
  assign push         = rv & (drop_q == '0) & ~(byp & instr_ready) & ~redirect;
  assign misalign_err = misalign_q;

  // next state: redirect re-targets the PC, flushes the buffer and turns every in-flight response into a drop
  always_comb begin
    pc_d       = redirect ? (redirect_pc & ~32'd3) : (fire ? pc_q + 32'd4 : pc_q);
    out_d      = out_q + CW'(fire) - CW'(rv);
    pwp_d      = pwp_q + AW'(fire);
    prp_d      = prp_q + AW'(rv);
    wp_d       = redirect ? '0 : wp_q + AW'(push);
    rp_d       = redirect ? '0 : rp_q + AW'(pop);
    cnt_d      = redirect ? '0 : cnt_q + CW'(push) - CW'(pop);
    drop_d     = redirect ? out_d : drop_q - CW'(rv & (drop_q != '0));
    misalign_d = redirect & (redirect_pc[1:0] != 2'b00);
  end

  // control registers, cleared immediately on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      wp_q       <= '0;
      rp_q       <= '0;
      pwp_q      <= '0;
      prp_q      <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      pwp_q      <= pwp_d;
      prp_q      <= prp_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      misalign_q <= misalign_d;
    end
  end

  // storage: request PCs wait in order for their responses, accepted words wait for decode
  always_ff @(posedge clk) begin
    if (fire) pend_pc[pwp_q] <= pc_q;
    if (push) begin
      buf_instr[wp_q] <= imem_rdata;
      buf_pc[wp_q]    <= pend_pc[prp_q];
    end
  end

  // a response with nothing outstanding is a memory protocol violation
  always_ff @(posedge clk) begin
    if (rst_n && imem_rvalid) assert (out_q != '0);
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and randomized checks of instr_fetch against a program-order fetch model.
module tb_instr_fetch;
  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n, imem_req, imem_gnt, imem_rvalid, instr_valid, instr_ready, redirect, misalign_err;
  logic [31:0] imem_addr, imem_rdata, instruction, instr_pc, redirect_pc;

  int checks = 0, errors = 0, cyc = 0, n_cons = 0, n0;
  logic [31:0] respq[$];
  int dueq[$];
  bit hold, rand_lat, stalled, exp_mis, cap_pc, cap_fetch;
  logic [31:0] exp_pc, exp_fetch, stall_pc, stall_ins, first_pc, first_fetch, last_grant, wrap_addr;

  instr_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instruction(instruction), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock cycle: drive at negedge, check mid-cycle, then advance the model to what the next posedge does
  task automatic cycle(input bit gnt, input bit rdy, input bit redir, input logic [31:0] rpc);
    @(negedge clk);
    imem_gnt = gnt; instr_ready = rdy; redirect = redir; redirect_pc = rpc;
    imem_rvalid = !hold && respq.size() != 0 && dueq[0] <= cyc;
    imem_rdata = imem_rvalid ? word(respq[0]) : $urandom;
    #1;
    chk1("misalign_err", misalign_err, exp_mis);
    if (redir) chk1("req_in_redirect", imem_req, 1'b0);
    if (imem_req) chk32("imem_addr", imem_addr, exp_fetch);
    if (stalled) begin
      chk1("stall_valid", instr_valid, 1'b1);
      chk32("stall_pc", instr_pc, stall_pc);
      chk32("stall_instr", instruction, stall_ins);
    end
    if (instr_valid && rdy) begin
      chk32("instr_pc", instr_pc, exp_pc);
      chk32("instruction", instruction, word(exp_pc));
      if (cap_pc) begin first_pc = instr_pc; cap_pc = 0; end
      exp_pc += 32'd4;
      n_cons++;
    end
    if (imem_rvalid) begin void'(respq.pop_front()); void'(dueq.pop_front()); end
    if (imem_req && gnt) begin
      if (cap_fetch) begin first_fetch = imem_addr; cap_fetch = 0; end
      if (last_grant == 32'hFFFF_FFFC) wrap_addr = imem_addr;
      last_grant = imem_addr;
      respq.push_back(imem_addr);
      dueq.push_back(cyc + 1 + (rand_lat ? int'($urandom_range(0, 3)) : 0));
      exp_fetch += 32'd4;
    end
    chk1("credit_bound", respq.size() <= DEPTH, 1'b1);
    stalled = instr_valid && !rdy && !redir;
    stall_pc = instr_pc;
    stall_ins = instruction;
    exp_mis = redir && (rpc[1:0] != 2'b00);
    if (redir) begin
      exp_pc = rpc & ~32'd3;
      exp_fetch = rpc & ~32'd3;
      cap_pc = 1; cap_fetch = 1; last_grant = '0;
    end
    cyc++;
  endtask

  // asynchronous reset mid-cycle; outputs must clear at once and fetch restarts at RESET_PC
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    imem_gnt = 0; imem_rvalid = 0; instr_ready = 0; redirect = 0; redirect_pc = '0; hold = 0;
    #1;
    chk1("rst_imem_req", imem_req, 1'b0);
    chk1("rst_instr_valid", instr_valid, 1'b0);
    chk32("rst_instruction", instruction, 32'h0);
    chk32("rst_instr_pc", instr_pc, 32'h0);
    chk1("rst_misalign", misalign_err, 1'b0);
    respq.delete(); dueq.delete();
    exp_pc = RPC; exp_fetch = RPC; exp_mis = 0; stalled = 0;
    cap_pc = 1; cap_fetch = 1; last_grant = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    instr_ready = 0; redirect = 0; redirect_pc = '0; hold = 0; rand_lat = 0;
    do_reset();

    // first fetch at RESET_PC, response one cycle after grant
    cycle(1, 1, 0, '0);
    chk1("t1_req", imem_req, 1'b1);
    chk32("t1_addr", imem_addr, RPC);
    cycle(1, 1, 0, '0);
`ifdef FETCH_BYPASS_EN
    chk1("t6_same_cycle_valid", instr_valid, 1'b1);
    chk32("t6_same_cycle_pc", instr_pc, RPC);
`else
    chk1("t6_no_bypass_valid", instr_valid, 1'b0);
    cycle(1, 1, 0, '0);
    chk1("t1_valid", instr_valid, 1'b1);
    chk32("t1_pc", instr_pc, RPC);
`endif
    repeat (10) cycle(1, 1, 0, '0);
    chk1("t1_progress", n_cons >= 5, 1'b1);

    // decoder stalls: buffer fills and requests stop; then drains in order
    repeat (5) cycle(1, 0, 0, '0);
    chk1("t2_req_stopped", imem_req, 1'b0);
    chk1("t2_valid_held", instr_valid, 1'b1);
    n0 = n_cons;
    repeat (8) cycle(1, 1, 0, '0);
    chk1("t2_drained", n_cons - n0 >= 2, 1'b1);

    // redirect with two requests in flight: both responses must be dropped
    hold = 1;
    repeat (6) cycle(1, 1, 0, '0);
    chk1("t3_two_outstanding", respq.size() == 2, 1'b1);
    cycle(1, 1, 1, 32'h0000_2000);
    hold = 0;
    repeat (10) cycle(1, 1, 0, '0);
    chk32("t3_first_pc", first_pc, 32'h0000_2000);
    chk32("t3_first_fetch", first_fetch, 32'h0000_2000);

    // misaligned redirect: one-cycle error pulse, fetch from the aligned address
    cycle(1, 1, 1, 32'h0000_2002);
    cycle(1, 1, 0, '0);
    chk1("t4_pulse", misalign_err, 1'b1);
    cycle(1, 1, 0, '0);
    chk1("t4_clear", misalign_err, 1'b0);
    repeat (8) cycle(1, 1, 0, '0);
    chk32("t4_fetch", first_fetch, 32'h0000_2000);
    chk32("t4_first_pc", first_pc, 32'h0000_2000);

    // PC wraps from the top of the address space to zero
    wrap_addr = 32'hDEAD_BEEF;
    cycle(1, 1, 1, 32'hFFFF_FFF8);
    repeat (12) cycle(1, 1, 0, '0);
    chk32("t5_wrap", wrap_addr, 32'h0000_0000);

    // randomized traffic: grant, ready, response latency/stall and redirects
    rand_lat = 1;
    n0 = n_cons;
    for (int i = 0; i < 3000; i++) begin
      hold = ($urandom_range(0, 99) < 15);
      cycle($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 3, $urandom);
    end
    hold = 0;
    chk1("random_progress", n_cons - n0 > 200, 1'b1);

    // reset in the middle of traffic
    repeat (5) cycle(1, 1, 0, '0);
    do_reset();
    repeat (20) cycle(1, 1, 0, '0);
    chk32("reset_restart_fetch", first_fetch, RPC);
    chk32("reset_restart_pc", first_pc, RPC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
